// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the MIPS instruction-fetch stage: state encoding,
// default widths, exception vector and the sequential PC increment.
package fetch_stage_pkg;

  localparam int         PC_W_DEF       = 8;
  localparam int         INSTR_W_DEF    = 32;
  localparam logic [7:0] EXC_VECTOR_DEF = 8'h80;
  localparam int         PC_INCR        = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load enable captures a fetched word and marks it
// valid; clear drops only the valid bit so the payload keeps its old value.
module if_id_reg #(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 32
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset,
  input  logic               en,
  input  logic               clr,
  input  logic [INSTR_W-1:0] instr_d,
  input  logic [PC_W-1:0]    pc_plus4_d,
  output logic [INSTR_W-1:0] instr_q,
  output logic [PC_W-1:0]    pc_plus4_q,
  output logic               valid_q
);

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      instr_q    <= '0;
      pc_plus4_q <= '0;
      valid_q    <= 1'b0;
    end else if (clr) begin
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q    <= instr_d;
      pc_plus4_q <= pc_plus4_d;
      valid_q    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, IDLE/RUN/FAULT control and the IF/ID
// register feeding decode. Misaligned PCs trap to FAULT and record the EPC.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W       = PC_W_DEF,
  parameter int              INSTR_W    = INSTR_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter logic [PC_W-1:0] EXC_VECTOR = PC_W'(EXC_VECTOR_DEF)
) (
  input  logic               SYS_clk,
  input  logic               SYS_reset,
  input  logic               SYS_load,
  input  logic [PC_W-1:0]    SYS_pc_val,
  input  logic               IF_stall,
  input  logic               IF_branch_taken,
  input  logic [PC_W-1:0]    IF_branch_target,
  input  logic               IF_exc_ack,
  output logic [PC_W-1:0]    IF_imem_pc,
  input  logic [INSTR_W-1:0] IF_imem_instruction,
  output logic [INSTR_W-1:0] IF_ID_instruction,
  output logic [PC_W-1:0]    IF_ID_pc_plus4,
  output logic               IF_ID_valid,
  output logic               IF_misaligned,
  output logic [PC_W-1:0]    IF_epc,
  output fetch_state_t       dbg_state
);

  fetch_state_t    state_q, state_nxt;
  logic [PC_W-1:0] pc_q, pc_nxt;
  logic [PC_W-1:0] epc_q, epc_nxt;
  logic [PC_W-1:0] pc_plus4;
  logic            id_en, id_clr;

  assign pc_plus4 = pc_q + PC_W'(PC_INCR);

  always_ff @(posedge SYS_clk or negedge SYS_reset) begin
    if (!SYS_reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      epc_q   <= '0;
    end else begin
      state_q <= state_nxt;
      pc_q    <= pc_nxt;
      epc_q   <= epc_nxt;
    end
  end

  // IF_ID_valid is a one-way valid with no ready: decode consumes every cycle
  // it is high; a stall holds the same word (and valid) in place.
  always_comb begin
    state_nxt = state_q;
    pc_nxt    = pc_q;
    epc_nxt   = epc_q;
    id_en     = 1'b0;
    id_clr    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (SYS_load) begin
          pc_nxt    = SYS_pc_val;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (SYS_load) begin
          pc_nxt = SYS_pc_val;
          id_clr = 1'b1;
        end else if (pc_q[1:0] != 2'b00) begin
          state_nxt = ST_FAULT;
          epc_nxt   = pc_q;
          id_clr    = 1'b1;
        end else if (IF_stall) begin
          // Branch is deliberately ignored here; its source keeps it asserted.
          pc_nxt = pc_q;
        end else if (IF_branch_taken) begin
          pc_nxt = IF_branch_target;
          id_clr = 1'b1;
        end else begin
          pc_nxt = pc_plus4;
          id_en  = 1'b1;
        end
      end
      ST_FAULT: begin
        if (SYS_load) begin
          pc_nxt    = SYS_pc_val;
          state_nxt = ST_RUN;
        end else if (IF_exc_ack) begin
          pc_nxt    = EXC_VECTOR;
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  if_id_reg #(
    .PC_W    (PC_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .SYS_clk    (SYS_clk),
    .SYS_reset  (SYS_reset),
    .en         (id_en),
    .clr        (id_clr),
    .instr_d    (IF_imem_instruction),
    .pc_plus4_d (pc_plus4),
    .instr_q    (IF_ID_instruction),
    .pc_plus4_q (IF_ID_pc_plus4),
    .valid_q    (IF_ID_valid)
  );

  assign IF_imem_pc    = pc_q;
  assign IF_misaligned = (state_q == ST_FAULT);
  assign IF_epc        = epc_q;
  assign dbg_state     = state_q;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the MIPS core: owns the program counter, drives the instruction-memory address, and registers the fetched word into the IF/ID pipeline register for the decode/register-file stage. It handles external PC load, stall, taken-branch redirect with squash, and misaligned-fetch faults, and reports the faulting PC for the exception logic.

## Interface
- PC_W, 8, PC and instruction-address width
- INSTR_W, 32, instruction width
- RESET_PC, 8'h00, PC value after reset
- EXC_VECTOR, 8'h80, PC loaded on exception acknowledge
- SYS_clk  in  1  system clock, all state on rising edge
- SYS_reset  in  1  asynchronous, active-low reset
- SYS_load  in  1  load PC from SYS_pc_val (highest priority)
- SYS_pc_val  in  PC_W  PC value for SYS_load
- IF_stall  in  1  hold PC and IF/ID contents
- IF_branch_taken  in  1  redirect PC to IF_branch_target
- IF_branch_target  in  PC_W  branch/jump target
- IF_exc_ack  in  1  exception handler acknowledge, leaves FAULT
- IF_imem_pc  out  PC_W  address to instruction memory (= PC register)
- IF_imem_instruction  in  INSTR_W  combinational read data from instruction memory
- IF_ID_instruction  out  INSTR_W  registered instruction to decode
- IF_ID_pc_plus4  out  PC_W  registered PC+4 of that instruction
- IF_ID_valid  out  1  IF/ID holds a real instruction
- IF_misaligned  out  1  in FAULT state
- IF_epc  out  PC_W  PC that caused the fault

## Operation
- States: IDLE (after reset, no fetch), RUN, FAULT.
- IDLE: PC holds; IF_ID_valid=0. SYS_load -> PC<=SYS_pc_val, go RUN.
- RUN, per cycle, priority order:
  - SYS_load: PC<=SYS_pc_val, IF_ID_valid<=0 (squash), stay RUN.
  - PC[1:0]!=0: go FAULT, IF_epc<=PC, IF_ID_valid<=0, PC holds.
  - IF_stall: PC, IF_ID_* all hold; IF_branch_taken ignored (source must hold it).
  - IF_branch_taken: PC<=IF_branch_target, IF_ID_valid<=0 (wrong-path word squashed).
  - else: PC<=PC+4; IF_ID_instruction<=IF_imem_instruction, IF_ID_pc_plus4<=PC+4, IF_ID_valid<=1.
- FAULT: no fetch, IF_ID_valid=0, IF_misaligned=1. SYS_load -> PC<=SYS_pc_val, RUN. Else IF_exc_ack -> PC<=EXC_VECTOR, RUN. IF_stall ignored.
- IF_epc written only on RUN->FAULT; holds otherwise.
- Arithmetic: PC+4 is modulo 2^PC_W; 8'hFC+4 = 8'h00, no flag.
- Squashed IF/ID: instruction and pc_plus4 hold previous values; only valid cleared.

## Timing
- Reset (async assert, any state): state=IDLE, PC=RESET_PC, IF_ID_instruction=0, IF_ID_pc_plus4=0, IF_ID_valid=0, IF_misaligned=0, IF_epc=0. Deassertion takes effect at next rising edge.
- IF_imem_pc is combinational from the PC register; IMEM read is combinational, same cycle.
- Fetch latency: instruction at PC appears on IF_ID_* one edge after PC is presented.
- Redirect (load/branch/ack): new PC visible on IF_imem_pc the cycle after the request; its instruction on IF_ID_* one cycle later; exactly one bubble between.
- Misaligned detection: in the first RUN cycle with PC[1:0]!=0; IF_misaligned rises the next edge.
- Reset mid-stall or mid-FAULT: clears everything, including IF_epc.

## Structure
- Shared package: state encoding (IDLE/RUN/FAULT), PC_W/INSTR_W defaults, EXC_VECTOR, the PC increment constant 4.
- One sub-module: if_id_reg (IF/ID pipeline register with enable and valid-clear); PC register and state machine stay in fetch_stage.

## Test plan
- Reset then SYS_load with SYS_pc_val=8'h10, IMEM[0x10]=32'h0123_4567 -> one cycle later IF_imem_pc=8'h10; next edge IF_ID_instruction=32'h0123_4567, IF_ID_pc_plus4=8'h14, IF_ID_valid=1.
- Run from 8'hF8 -> IF_imem_pc sequence F8, FC, 00, 04; IF_ID_pc_plus4 of PC 8'hFC = 8'h00.
- IF_stall high 3 cycles at PC=8'h20 -> IF_imem_pc stays 8'h20, IF_ID_* unchanged for 3 cycles, then resumes at 8'h24; branch asserted during stall ignored.
- IF_branch_taken with target 8'h40 at PC=8'h08 -> next IF_imem_pc=8'h40, IF_ID_valid=0 one cycle, then instruction from 8'h40 with pc_plus4 8'h44.
- Branch target 8'h42 -> FAULT: IF_misaligned=1, IF_epc=8'h42, IF_ID_valid=0; IF_exc_ack -> IF_imem_pc=8'h80, IF_misaligned=0.
- Assert SYS_reset low mid-FAULT with SYS_load high -> all outputs reset values immediately, state IDLE; SYS_load ignored until reset deasserted.
